// File: rtl/tone_sequencer.sv
// Tone sequencer: buffers (half-period, duration) note commands and plays them as a square wave.
// Define SOUNDGEN_GAP_EN to insert GAP_TICKS ticks of silence after every note.
module tone_sequencer #(
  parameter int PW         = 16,
  parameter int LW         = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int GAP_TICKS  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  tick_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [PW-1:0]         cmd_period_i,
  input  logic [LW-1:0]         cmd_len_i,
  output logic                  tone_o,
  output logic                  busy_o,
  output logic                  note_done_o,
  output logic [DEPTH_LOG2:0]   level_o
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  if (GAP_TICKS < 0) begin : g_bad_gap
    $error("GAP_TICKS must be non-negative");
  end

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  state_t state, state_nx;

  logic [PW-1:0]         fifo_per [DEPTH];
  logic [LW-1:0]         fifo_len [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, push, pop;
  logic [PW-1:0]         head_per, period_r, per_cnt;
  logic [LW-1:0]         head_len, remaining;
  logic                  note_end, skip_pend, select;

  assign full        = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  assign pop         = (state == LOAD);
  assign head_per    = fifo_per[rd_ptr];
  assign head_len    = fifo_len[rd_ptr];
  assign level_o     = count;
  assign busy_o      = (state != IDLE);
  assign note_end    = (state == PLAY) && tick_i && (remaining == LW'(1));

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_per[wr_ptr] <= cmd_period_i;
      fifo_len[wr_ptr] <= cmd_len_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef SOUNDGEN_GAP_EN
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  logic [GW-1:0] gap_cnt;
  logic          gap_done;

  assign gap_done = (GAP_TICKS == 0) || (tick_i && gap_cnt == GW'(GAP_TICKS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               gap_cnt <= '0;
    else if (state != GAP)   gap_cnt <= '0;
    else if (tick_i)         gap_cnt <= gap_cnt + GW'(1);
  end
`endif

  always_comb begin
    state_nx = state;
    select   = 1'b0;
    case (state)
      IDLE: if (enable_i && count != '0) state_nx = LOAD;
      LOAD: state_nx = (head_len == '0) ? IDLE : PLAY;
      PLAY: begin
        if (note_end) begin
`ifdef SOUNDGEN_GAP_EN
          state_nx = GAP;
`else
          select = 1'b1;
`endif
        end
      end
`ifdef SOUNDGEN_GAP_EN
      GAP:  if (gap_done) select = 1'b1;
`endif
      default: state_nx = IDLE;
    endcase
    // enable_i only gates the start of the next note, never the current one
    if (select) state_nx = (enable_i && count != '0) ? LOAD : IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      tone_o      <= 1'b0;
      note_done_o <= 1'b0;
      skip_pend   <= 1'b0;
      period_r    <= '0;
      per_cnt     <= '0;
      remaining   <= '0;
    end else begin
      state       <= state_nx;
      // a zero-length note reports done one cycle after the IDLE it drops into
      skip_pend   <= pop && (head_len == '0);
      note_done_o <= note_end || skip_pend;
      case (state)
        LOAD: begin
          period_r  <= head_per;
          remaining <= head_len;
          per_cnt   <= '0;
          tone_o    <= 1'b0;
        end
        PLAY: begin
          if (note_end) begin
            tone_o <= 1'b0;
          end else begin
            if (tick_i) remaining <= remaining - LW'(1);
            if (period_r != '0) begin
              if (per_cnt == period_r - PW'(1)) begin
                per_cnt <= '0;
                tone_o  <= ~tone_o;
              end else begin
                per_cnt <= per_cnt + PW'(1);
              end
            end
          end
        end
        default: tone_o <= 1'b0;
      endcase
    end
  end
endmodule
